// File: rtl/booth_multiplier_pkg.sv
// Shared ALU definitions for the radix-4 Booth multiplier: FSM states,
// Booth partial-product select codes and datapath widths.
package booth_multiplier_pkg;

  localparam int unsigned OPW  = 32;  // operand width
  localparam int unsigned ACCW = 34;  // accumulator width, wide enough for +/-2M
  localparam int unsigned ITER = 16;  // two multiplier bits retired per iteration
  localparam int unsigned CNTW = 4;   // iteration counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM   = 3'd1,
    P2M  = 3'd2,
    NM   = 3'd3,
    N2M  = 3'd4
  } booth_sel_e;

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: maps the triplet {Q[1], Q[0], q-1} onto the
// partial-product selection applied to the multiplicand this iteration.
module booth_recoder
  import booth_multiplier_pkg::*;
(
  input  logic [2:0] triplet_i,
  output booth_sel_e sel_o
);

  // Triplet to select-code lookup
  always_comb begin
    sel_o = ZERO;
    case (triplet_i)
      3'b000:  sel_o = ZERO;
      3'b001:  sel_o = PM;
      3'b010:  sel_o = PM;
      3'b011:  sel_o = P2M;
      3'b100:  sel_o = N2M;
      3'b101:  sel_o = NM;
      3'b110:  sel_o = NM;
      3'b111:  sel_o = ZERO;
      default: sel_o = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed 32x32 -> 64 multiplier, radix-4 Booth, 16 iterations.
// result packs {HI, LO} and only changes on completion or reset.
module booth_multiplier
  import booth_multiplier_pkg::*;
(
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [OPW-1:0]      A,
  input  logic [OPW-1:0]      B,
  output logic                busy,
  output logic                done,
  output logic [2*OPW-1:0]    result
);

  state_e             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [OPW-1:0]     m_q, m_d;
  logic [ACCW-1:0]    p_q, p_d;
  logic [OPW-1:0]     q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [2*OPW-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  booth_sel_e         sel_s;
  logic [ACCW-1:0]    m_ext_s;
  logic [ACCW-1:0]    m2_ext_s;
  logic [ACCW-1:0]    addend_s;
  logic [ACCW-1:0]    sum_s;
  logic [ACCW-1:0]    p_sh_s;
  logic [OPW-1:0]     q_sh_s;

  booth_recoder u_recoder (
    .triplet_i ({q_q[1:0], qm1_q}),
    .sel_o     (sel_s)
  );

  assign m_ext_s  = {{(ACCW-OPW){m_q[OPW-1]}}, m_q};
  assign m2_ext_s = {m_ext_s[ACCW-2:0], 1'b0};

  // Partial product selected by the recoder
  always_comb begin
    addend_s = '0;
    case (sel_s)
      ZERO:    addend_s = '0;
      PM:      addend_s = m_ext_s;
      P2M:     addend_s = m2_ext_s;
      NM:      addend_s = ACCW'(0) - m_ext_s;
      N2M:     addend_s = ACCW'(0) - m2_ext_s;
      default: addend_s = '0;
    endcase
  end

  // Accumulate (wrapping) then arithmetic shift {P, Q, q-1} right by two
  assign sum_s  = p_q + addend_s;
  assign p_sh_s = {{2{sum_s[ACCW-1]}}, sum_s[ACCW-1:2]};
  assign q_sh_s = {sum_s[1:0], q_q[OPW-1:2]};

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    p_d      = p_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          m_d     = A;
          q_d     = B;
          qm1_d   = 1'b0;
          p_d     = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        p_d   = p_sh_s;
        q_d   = q_sh_s;
        qm1_d = q_q[1];
        if (cnt_q == CNTW'(ITER - 1)) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = {p_sh_s[OPW-1:0], q_sh_s};
        end else begin
          cnt_d    = cnt_q + CNTW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered outputs; clear discards any operation
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      m_q      <= '0;
      p_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      p_q      <= p_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed and light random checks of booth_multiplier and booth_recoder.
module tb_booth_multiplier;
  import booth_multiplier_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A     = 32'd0;
  logic [31:0] B     = 32'd0;
  logic        busy;
  logic        done;
  logic [63:0] result;

  logic [2:0]  rec_trip = 3'd0;
  booth_sel_e  rec_sel;

  int n_checks = 0;
  int n_pass   = 0;

  booth_multiplier dut (
    .clock  (clock),
    .clear  (clear),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  booth_recoder u_rec (
    .triplet_i (rec_trip),
    .sel_o     (rec_sel)
  );

  always #5 clock = ~clock;

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: actual=0x%016h required=0x%016h", tag, obs, exp);
  endtask

  // Issue one multiply, hold start until busy, then measure latency/busy width.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    int k;
    int lat;
    int busy_cnt;
    A = a; B = b; start = 1'b1;
    k = 0;
    do begin
      @(posedge clock); #1; k++;
    end while (!busy && k < 5);
    start = 1'b0;
    A = $urandom; B = $urandom;
    check_val({tag, "_accept"}, 64'(busy), 64'd1);
    busy_cnt = 1;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clock); #1; lat++;
      if (busy) busy_cnt++;
    end
    check_val({tag, "_latency"}, 64'(lat), 64'd16);
    check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd16);
    check_val({tag, "_result"}, result, exp);
  endtask

  // One cycle after done: done must drop and result must hold.
  task automatic check_hold(input logic [63:0] exp, input string tag);
    @(posedge clock); #1;
    check_val({tag, "_done_fall"}, 64'(done), 64'd0);
    check_val({tag, "_hold"}, result, exp);
    repeat (3) @(posedge clock);
    #1;
    check_val({tag, "_hold3"}, result, exp);
  endtask

  localparam logic [2:0] REC_EXP [8] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd4, 3'd3, 3'd3, 3'd0};

  initial begin
    int k;
    int extra_done;
    logic [31:0] ra, rb;
    logic [63:0] rexp;

    // Recoder table
    for (int i = 0; i < 8; i++) begin
      rec_trip = 3'(i);
      #1;
      check_val($sformatf("recoder_%0d", i), 64'(rec_sel), 64'(REC_EXP[i]));
    end

    // Reset state
    #1;
    check_val("reset_busy", 64'(busy), 64'd0);
    check_val("reset_done", 64'(done), 64'd0);
    check_val("reset_result", result, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    do_mul(32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "7x-3");
    check_hold(64'hFFFF_FFFF_FFFF_FFEB, "7x-3");
    do_mul(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_x_min");
    do_mul(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, "min_x_1");
    do_mul(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "max_x_max");
    do_mul(32'd0, 32'hFFFF_FFFF, 64'd0, "0x-1");
    check_hold(64'd0, "0x-1");
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, "-1x-1");
    check_hold(64'd1, "-1x-1");

    // Mid-operation reset
    A = 32'd9; B = 32'd9; start = 1'b1;
    k = 0;
    do begin
      @(posedge clock); #1; k++;
    end while (!busy && k < 5);
    start = 1'b0;
    repeat (7) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    #1;
    check_val("midrst_busy", 64'(busy), 64'd0);
    check_val("midrst_done", 64'(done), 64'd0);
    check_val("midrst_result", result, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    check_val("midrst_idle_busy", 64'(busy), 64'd0);
    check_val("midrst_idle_result", result, 64'd0);
    do_mul(32'd12, 32'd12, 64'd144, "12x12");

    // Request during RUN is dropped
    @(negedge clock);
    A = 32'd3; B = 32'd4; start = 1'b1;
    k = 0;
    do begin
      @(posedge clock); #1; k++;
    end while (!busy && k < 5);
    start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    A = 32'd5; B = 32'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      @(posedge clock); #1; k++;
    end
    check_val("ignored_done_seen", 64'(done), 64'd1);
    check_val("ignored_result", result, 64'd12);
    extra_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      if (done) extra_done++;
    end
    check_val("ignored_no_second_done", 64'(extra_done), 64'd0);
    check_val("ignored_idle", 64'(busy), 64'd0);

    // Random pairs back-to-back against a 64-bit reference product
    @(negedge clock);
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'h8000_0000;
      rexp = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
      do_mul(ra, rb, rexp, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
